// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus.
//   imem_req   : fetch request, driven by the fetch unit
//   imem_addr  : byte address of the fetch
//   imem_rdata : instruction word, valid when imem_ready=1
//   imem_ready : memory response strobe
// master = fetch unit side, slave = instruction memory side.
interface fetch_unit_if #(
  parameter int N = 32
);
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic [N-1:0] imem_rdata;
  logic         imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing stage.
// Fetches one instruction per FETCH/EXEC pair, holds it in instr for the
// execute window, and computes the next PC from the controller outputs
// when the window closes.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   imem            : instruction memory bus (master side)
//   stall           : holds the EXEC state
//   branch, zero, jump, jrSelect, jr_target : next-PC controls
//   instr, opCode, instr_valid : instruction register and decode hint
//   pc, pc_plus4    : address of instr and its link value
//   retired_count   : number of instructions retired
//
// state | meaning
// FETCH | request at pc, wait for imem_ready, capture word
// EXEC  | instr valid for the controller; leave when stall drops
module fetch_unit #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         branch,
  input  logic         zero,
  input  logic         jump,
  input  logic         jrSelect,
  input  logic [N-1:0] jr_target,
  output logic [N-1:0] instr,
  output logic [4:0]   opCode,
  output logic         instr_valid,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic [31:0]  retired_count
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic         load_instr;
  logic         advance;
  logic [N-1:0] next_pc;
  logic [N-1:0] branch_offset;
  logic [N-1:0] jump_target;

  assign pc_plus4 = pc + N'(4);
  assign opCode   = instr[N-1:N-5];

  // Word offset of the branch, sign-extended and scaled to bytes.
  assign branch_offset = {{(N-18){instr[15]}}, instr[15:0], 2'b00};
  // Region bits come from pc_plus4 so a jump in the last slot of a
  // region lands in the following one.
  assign jump_target   = {pc_plus4[N-1:N-3], instr[N-6:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jrSelect) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset;
    end
  end

  always_comb begin
    state_d         = state_q;
    load_instr      = 1'b0;
    advance         = 1'b0;
    // Both strobes are forced low while reset is held, whatever the state.
    imem.imem_req   = 1'b0;
    instr_valid     = 1'b0;
    imem.imem_addr  = pc;
    case (state_q)
      FETCH: begin
        imem.imem_req = !reset;
        if (imem.imem_ready) begin
          load_instr = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        instr_valid = !reset;
        if (!stall) begin
          advance = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc            <= RESET_PC;
      instr         <= '0;
      retired_count <= '0;
    end else begin
      state_q <= state_d;
      if (load_instr) begin
        instr <= imem.imem_rdata;
      end
      if (advance) begin
        pc            <= next_pc;
        retired_count <= retired_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch, zero, jump, jrSelect;
  logic [31:0] jr_target;
  logic [31:0] instr, pc, pc_plus4, retired_count;
  logic [4:0]  opCode;
  logic        instr_valid;

  int total = 0;
  int passed = 0;

  fetch_unit_if #(.N(32)) bus ();

  fetch_unit #(.N(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (bus),
    .stall         (stall),
    .branch        (branch),
    .zero          (zero),
    .jump          (jump),
    .jrSelect      (jrSelect),
    .jr_target     (jr_target),
    .instr         (instr),
    .opCode        (opCode),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  // Reference model: an instruction is either waiting to be fetched or
  // sitting in its execute window.
  logic [31:0] m_pc, m_instr, m_ret;
  bit          m_exec;

  function automatic logic [31:0] ref_next_pc(logic [31:0] cur, logic [31:0] iw,
                                              logic br, logic zr, logic jp,
                                              logic jr, logic [31:0] tgt);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(iw[15:0])) * 4;
    if (jr)            return tgt;
    else if (jp)       return (seq & 32'hE000_0000) | ((iw & 32'h07FF_FFFF) * 4);
    else if (br && zr) return seq + 32'(off);
    else               return seq;
  endfunction

  task automatic model_update();
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_ret = 32'h0; m_exec = 0;
    end else if (!m_exec) begin
      if (bus.imem_ready) begin
        m_instr = bus.imem_rdata;
        m_exec  = 1;
      end
    end else if (!stall) begin
      m_pc   = ref_next_pc(m_pc, m_instr, branch, zero, jump, jrSelect, jr_target);
      m_ret  = m_ret + 32'd1;
      m_exec = 0;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all();
    chk("imem_req",      32'(bus.imem_req), 32'(!reset && !m_exec));
    chk("instr_valid",   32'(instr_valid),  32'(!reset && m_exec));
    chk("imem_addr",     bus.imem_addr,     m_pc);
    chk("pc",            pc,                m_pc);
    chk("pc_plus4",      pc_plus4,          m_pc + 32'd4);
    chk("instr",         instr,             m_instr);
    chk("opCode",        32'(opCode),       m_instr >> 27);
    chk("retired_count", retired_count,     m_ret);
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_ctl();
    stall = 0; branch = 0; zero = 0; jump = 0; jrSelect = 0; jr_target = 32'h0;
  endtask

  task automatic go_fetch();
    clear_ctl();
    bus.imem_ready = 0;
    for (int i = 0; i < 4 && m_exec; i++) step();
    chk("reach_fetch", 32'(m_exec), 32'(0));
  endtask

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] iw;
    logic        br, zr, jp, jr;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h0000_FFFE, 1, 1, 0, 0, 32'h0,    32'h0000_000C};
    vecs[1] = '{32'h0000_0010, 32'h0000_FFFE, 1, 0, 0, 0, 32'h0,    32'h0000_0014};
    vecs[2] = '{32'h0000_0020, 32'h0000_0040, 0, 0, 1, 0, 32'h0,    32'h0000_0100};
    vecs[3] = '{32'h0000_0020, 32'h0000_0040, 0, 0, 1, 1, 32'h400,  32'h0000_0400};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 0, 32'h0,    32'h0000_0000};
    vecs[5] = '{32'h0000_0100, 32'h0000_0010, 1, 1, 0, 0, 32'h0,    32'h0000_0144};
    vecs[6] = '{32'hE000_0000, 32'h07FF_FFFF, 0, 0, 1, 0, 32'h0,    32'hFFFF_FFFC};
    vecs[7] = '{32'h0000_0008, 32'hFFFF_FFFF, 1, 1, 1, 1, 32'h1233, 32'h0000_1233};
    vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0001, 1, 1, 0, 0, 32'h0,    32'h0000_0004};
    vecs[9] = '{32'h1FFF_FFFC, 32'h0000_0000, 0, 0, 1, 0, 32'h0,    32'h2000_0000};

    clear_ctl();
    reset = 1; bus.imem_ready = 0; bus.imem_rdata = 32'h0;
    m_pc = 0; m_instr = 0; m_ret = 0; m_exec = 0;
    @(negedge clk);

    // Reset, then zero-wait sequential fetch
    step();
    reset = 0;
    bus.imem_ready = 1; bus.imem_rdata = 32'h0800_0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i % 2 == 0) begin
        chk("seq_addr", bus.imem_addr, 32'(i * 2));
        chk("seq_valid_lo", 32'(instr_valid), 32'(0));
      end else begin
        chk("seq_valid_hi", 32'(instr_valid), 32'(1));
        chk("seq_opcode", 32'(opCode), 32'h1);
      end
      step();
    end
    chk("seq_retired", retired_count, 32'd4);

    // Memory wait states at address 0
    reset = 1; step(); reset = 0;
    bus.imem_ready = 0; bus.imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_req", 32'(bus.imem_req), 32'(1));
      chk("wait_addr", bus.imem_addr, 32'h0);
      chk("wait_valid", 32'(instr_valid), 32'(0));
      step();
    end
    bus.imem_ready = 1;
    step();
    chk("wait_exec", 32'(instr_valid), 32'(1));
    chk("wait_instr", instr, 32'h1234_5678);

    // Directed next-PC vectors
    for (int k = 0; k < 10; k++) begin
      go_fetch();
      bus.imem_ready = 1; bus.imem_rdata = 32'h0;
      step();
      jrSelect = 1; jr_target = vecs[k].start_pc;
      step();
      clear_ctl();
      chk($sformatf("vec%0d_start", k), bus.imem_addr, vecs[k].start_pc);
      bus.imem_rdata = vecs[k].iw;
      step();
      bus.imem_ready = 0;
      branch = vecs[k].br; zero = vecs[k].zr; jump = vecs[k].jp;
      jrSelect = vecs[k].jr; jr_target = vecs[k].tgt;
      step();
      clear_ctl();
      chk($sformatf("vec%0d_next_pc", k), bus.imem_addr, vecs[k].exp_pc);
    end

    // Stall for 4 cycles in EXEC
    begin
      logic [31:0] p, r;
      go_fetch();
      bus.imem_ready = 1; bus.imem_rdata = 32'hA5A5_0001;
      step();
      bus.imem_ready = 0;
      p = pc; r = retired_count;
      stall = 1; branch = 1; zero = 1;
      for (int i = 0; i < 4; i++) begin
        #1;
        chk("stall_valid", 32'(instr_valid), 32'(1));
        chk("stall_pc", pc, p);
        chk("stall_ret", retired_count, r);
        step();
      end
      stall = 0; branch = 0; zero = 0;
      step();
      chk("stall_release_pc", pc, p + 32'd4);
      chk("stall_release_ret", retired_count, r + 32'd1);
    end

    // Reset while fetching, with a response in the same cycle
    go_fetch();
    chk("midreset_pc_nonzero", 32'(pc != 32'h0), 32'(1));
    reset = 1; bus.imem_ready = 1; bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    reset = 0; bus.imem_ready = 0;
    chk("midreset_instr", instr, 32'h0);
    chk("midreset_pc", pc, 32'h0);
    step();

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 60) == 0);
      bus.imem_ready = $urandom_range(0, 1) == 1;
      bus.imem_rdata = $urandom;
      stall          = ($urandom_range(0, 2) == 0);
      branch         = $urandom_range(0, 1) == 1;
      zero           = $urandom_range(0, 1) == 1;
      jump           = ($urandom_range(0, 3) == 0);
      jrSelect       = ($urandom_range(0, 4) == 0);
      jr_target      = $urandom;
      step();
    end
    reset = 0;
    clear_ctl();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch and PC sequencing stage that sits directly upstream of the controller.
- Fetches a 32-bit instruction from instruction memory over a ready handshake and holds it in an instruction register.
- Presents opCode (instr[31:27]) to the controller for exactly one execute window.
- At the end of that window, computes the next PC from the controller's branch/zero/jump/jrSelect outputs.

Parameters:
- N, 32, instruction and PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  N  byte address of fetch; equals pc
- imem_rdata  input  N  instruction word, valid when imem_ready=1
- imem_ready  input  1  memory response strobe
- stall  input  1  downstream hold; freezes the EXEC state
- branch  input  1  from controller
- zero  input  1  ALU zero flag
- jump  input  1  from controller
- jrSelect  input  1  from controller; jump-register
- jr_target  input  N  register-file read value used for jr
- instr  output  N  instruction register
- opCode  output  5  instr[31:27], to controller
- instr_valid  output  1  instr/opCode valid for execution this cycle
- pc  output  N  address of the instruction in instr
- pc_plus4  output  N  pc+4; link value for jal
- retired_count  output  32  number of instructions retired

Behaviour:
- Reset (synchronous, reset=1 at rising edge):
  - pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, retired_count=0, imem_req=0 on the cycle reset is asserted.
  - Reset overrides all other inputs.
- Reset mid-operation:
  - A pending fetch is abandoned.
  - An imem_ready arriving in the same cycle as reset is ignored.
- Two-state FSM: FETCH, EXEC.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_ready=1: instr<=imem_rdata, state<=EXEC.
  - Otherwise remain in FETCH with a stable address. There is no timeout.
- EXEC:
  - instr_valid=1, imem_req=0.
  - If stall=1: hold pc, instr and state; instr_valid stays 1.
  - If stall=0: pc<=next_pc, retired_count<=retired_count+1, state<=FETCH.
- Minimum per-instruction latency with zero-wait memory: 2 cycles (FETCH, EXEC).
- next_pc is combinational. Priority, highest first:
  - jrSelect: next_pc = jr_target
  - jump: next_pc = {pc_plus4[31:29], instr[26:0], 2'b00}
  - branch & zero: next_pc = pc_plus4 + (sign_extend(instr[15:0]) << 2)
  - otherwise: next_pc = pc_plus4
- Arithmetic and width rules:
  - All PC arithmetic is modulo 2^N; wrap from 32'hFFFF_FFFC to 0 is legal and unflagged.
  - branch=1 with zero=0 falls through to pc_plus4.
  - retired_count wraps from 32'hFFFF_FFFF to 0.
- Outputs and timing:
  - pc_plus4 = pc + 4, combinational.
  - opCode = instr[31:27], combinational from instr.
  - Control inputs are sampled only in EXEC with stall=0; they are ignored in FETCH.
  - No misalignment checking; jr_target low bits pass through unchanged.

Test Plan:
1. Reset then sequential fetch:
   - Stimulus: reset 1 cycle; zero-wait memory returns 32'h0800_0000 at every address.
   - Required: imem_addr sequence 0,4,8,C; instr_valid pulses every 2nd cycle; opCode=5'b00001; retired_count=4 after 8 cycles.
2. Memory wait states:
   - Stimulus: imem_ready delayed 3 cycles at address 0.
   - Required: imem_req and imem_addr=0 held stable for 3 cycles; instr_valid=0 throughout; EXEC entered on the cycle after ready.
3. Branch taken / not taken:
   - Stimulus: pc=0x10, instr[15:0]=16'hFFFE, branch=1, zero=1.
   - Required: next pc=0x0C.
   - Stimulus: same with zero=0.
   - Required: next pc=0x14.
4. Jump and jr priority:
   - Stimulus: pc=0x20, instr[26:0]=27'h40, jump=1.
   - Required: pc<=0x100.
   - Stimulus: jrSelect=1, jump=1, jr_target=0x400.
   - Required: pc<=0x400; pc_plus4 reads 0x24 during EXEC for the link.
5. Stall:
   - Stimulus: stall=1 for 4 cycles in EXEC.
   - Required: instr_valid=1 and pc unchanged for those cycles; retired_count unchanged; advances one cycle after stall drops.
6. Reset mid-fetch and PC wrap:
   - Stimulus: assert reset while in FETCH, with imem_ready=1 in the same cycle.
   - Required: instr stays 0 and pc=RESET_PC.
   - Stimulus: pc=32'hFFFF_FFFC, no control asserted.
   - Required: next pc=0.
